// File: rtl/ecc_61_pkg.sv
// Shared constants and check-byte function for the 61-bit SECDED FIFO ECC.
package ecc_61_pkg;

    localparam int unsigned DATA_WIDTH   = 61;
    localparam int unsigned PARITY_WIDTH = 8;
    localparam int unsigned HAM_BITS     = 7;

    // Flipping two Hamming bits gives a nonzero syndrome with even overall parity,
    // which the read-side decoder classifies as an uncorrectable double-bit error.
    localparam logic [PARITY_WIDTH-1:0] POISON_MASK = 8'h03;

    // Codeword positions run 1..68; data fills the non-power-of-two positions in order.
    function automatic logic [HAM_BITS-1:0][DATA_WIDTH-1:0] build_pos_masks();
        logic [HAM_BITS-1:0][DATA_WIDTH-1:0] masks;
        int unsigned pos;
        masks = '0;
        pos   = 1;
        for (int d = 0; d < DATA_WIDTH; d++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            for (int i = 0; i < HAM_BITS; i++) masks[i][d] = pos[i];
            pos++;
        end
        return masks;
    endfunction

    localparam logic [HAM_BITS-1:0][DATA_WIDTH-1:0] POS_MASK = build_pos_masks();

    function automatic logic [PARITY_WIDTH-1:0] calc_parity(input logic [DATA_WIDTH-1:0] data);
        logic [PARITY_WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < HAM_BITS; i++) p[i] = ^(data & POS_MASK[i]);
        p[PARITY_WIDTH-1] = ^{data, p[HAM_BITS-1:0]};
        return p;
    endfunction

endpackage

// File: rtl/ecc_61_enc_core.sv
// Combinational SECDED check-byte generator for one 61-bit word.
module ecc_61_enc_core
    import ecc_61_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [PARITY_WIDTH-1:0] parity
);

    assign parity = calc_parity(data);

endmodule

// File: rtl/ecc_61_enc_fault_detc.sv
// Write-side SECDED encoder with redundant encoder compare, check-byte poisoning and
// one registered valid/ready stage. Define ECC_ENC_FAULT_INJ_EN to add inj_en/inj_mask.
module ecc_61_enc_fault_detc
    import ecc_61_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ecc_fault_detc_en,
    input  logic                    bypass,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [PARITY_WIDTH-1:0] parity_out,
    output logic                    ecc_fault,
    output logic                    fault_sticky,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
`ifdef ECC_ENC_FAULT_INJ_EN
    input  logic                    inj_en,
    input  logic [PARITY_WIDTH-1:0] inj_mask,
`endif
    input  logic                    fault_clr
);

    logic [PARITY_WIDTH-1:0] enc0_parity, enc1_parity, enc1_cmp;
    logic                    accept, mismatch;

    logic                    out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [PARITY_WIDTH-1:0] parity_q, parity_d;
    logic                    fault_q, fault_d;
    logic                    sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    ecc_61_enc_core u_enc0 (
        .data   (data_in),
        .parity (enc0_parity)
    );

    ecc_61_enc_core u_enc1 (
        .data   (data_in),
        .parity (enc1_parity)
    );

`ifdef ECC_ENC_FAULT_INJ_EN
    assign enc1_cmp = inj_en ? (enc1_parity ^ inj_mask) : enc1_parity;
`else
    assign enc1_cmp = enc1_parity;
`endif

    assign in_rdy   = ~out_vld_q | out_rdy;
    assign accept   = in_vld & in_rdy;
    assign mismatch = (enc0_parity != enc1_cmp) & ecc_fault_detc_en & ~bypass;

    always_comb begin
        out_vld_d = out_vld_q;
        data_d    = data_q;
        parity_d  = parity_q;
        fault_d   = fault_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;

        if (accept) begin
            out_vld_d = 1'b1;
            data_d    = data_in;
            fault_d   = mismatch;
            if (bypass) begin
                parity_d = '0;
            end else begin
                parity_d = mismatch ? (enc0_parity ^ POISON_MASK) : enc0_parity;
            end
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end

        // A new fault in the same cycle as a clear takes precedence over the clear.
        if (accept && mismatch) begin
            sticky_d = 1'b1;
            if (fault_clr) begin
                cnt_d = CNT_WIDTH'(1);
            end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else if (fault_clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            data_q    <= '0;
            parity_q  <= '0;
            fault_q   <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            fault_q   <= fault_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_vld      = out_vld_q;
    assign data_out     = data_q;
    assign parity_out   = parity_q;
    assign ecc_fault    = fault_q;
    assign fault_sticky = sticky_q;
    assign fault_cnt    = cnt_q;

endmodule

// File: tb/tb_ecc_61_enc_fault_detc.sv
// Randomized self-checking bench for ecc_61_enc_fault_detc against a syndrome-sum model.
module tb_ecc_61_enc_fault_detc;

    localparam int DW = 61;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, bypass = 1'b0, in_vld = 1'b0, out_rdy = 1'b0, fault_clr = 1'b0;
    logic          inj_en = 1'b0;
    logic [7:0]    inj_mask = 8'h00;
    logic [DW-1:0] data_in = '0;
    logic          in_rdy, out_vld, ecc_fault, fault_sticky;
    logic [DW-1:0] data_out;
    logic [7:0]    parity_out, fault_cnt;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic          m_vld, m_fault, m_sticky;
    logic [DW-1:0] m_data;
    logic [7:0]    m_par, m_cnt;
    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];

    ecc_61_enc_fault_detc dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ecc_fault_detc_en (en),
        .bypass            (bypass),
        .in_vld            (in_vld),
        .in_rdy            (in_rdy),
        .data_in           (data_in),
        .out_vld           (out_vld),
        .out_rdy           (out_rdy),
        .data_out          (data_out),
        .parity_out        (parity_out),
        .ecc_fault         (ecc_fault),
        .fault_sticky      (fault_sticky),
        .fault_cnt         (fault_cnt),
`ifdef ECC_ENC_FAULT_INJ_EN
        .inj_en            (inj_en),
        .inj_mask          (inj_mask),
`endif
        .fault_clr         (fault_clr)
    );

    always #5 clk = ~clk;

    // Hamming bits equal the XOR of the codeword positions of all set data bits.
    function automatic logic [7:0] ref_parity(input logic [DW-1:0] d);
        logic [6:0] syn;
        int         idx;
        syn = '0;
        idx = 0;
        for (int pos = 1; pos <= 68; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (d[idx]) syn = syn ^ pos[6:0];
                idx++;
            end
        end
        return {(($countones(d) + $countones(syn)) % 2 == 1), syn};
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        m_vld = 0; m_fault = 0; m_sticky = 0; m_data = '0; m_par = '0; m_cnt = '0;
        sent.delete();
        got.delete();
    endtask

    // Drives one clock of stimulus, advances the model, returns 1 ns after the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
        logic acc, mm;
        in_vld  = v;
        data_in = d;
        out_rdy = r;
        #1;
        if (out_vld && r) got.push_back(data_out);
        acc = v && (!m_vld || r);
        mm  = acc && en && !bypass && inj_en && (inj_mask != 8'h00);
        if (acc) begin
            sent.push_back(d);
            m_vld   = 1;
            m_data  = d;
            m_fault = mm;
            m_par   = bypass ? 8'h00 : (ref_parity(d) ^ (mm ? 8'h03 : 8'h00));
        end else if (r) begin
            m_vld = 0;
        end
        if (mm) begin
            m_sticky = 1;
            if (fault_clr) m_cnt = 8'd1;
            else if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
        end else if (fault_clr) begin
            m_sticky = 0;
            m_cnt    = 8'd0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_vld, data_out, parity_out, ecc_fault, fault_sticky, fault_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b par=%h flt=%b stk=%b cnt=%0d want all 0",
                     out_vld, parity_out, ecc_fault, fault_sticky, fault_cnt);
        end
        rst_n = 1;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_rdy: got %b want 1", in_rdy);
        end
    endtask

    task automatic test_basic();
        en = 1; bypass = 0; inj_en = 0;
        cycle(1, 61'h0, 1);
        checks++;
        if ({out_vld, parity_out, ecc_fault} !== {1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL basic_zero: got vld=%b par=%h flt=%b want 1 00 0",
                     out_vld, parity_out, ecc_fault);
        end
        cycle(1, 61'h1, 1);
        checks++;
        if ({out_vld, data_out, parity_out, ecc_fault} !== {1'b1, 61'h1, 8'h83, 1'b0}) begin
            errors++;
            $display("FAIL basic_one: got vld=%b data=%h par=%h flt=%b want 1 1 83 0",
                     out_vld, data_out, parity_out, ecc_fault);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1, rand_word(), 1);
            checks++;
            if ({out_vld, data_out, parity_out} !== {1'b1, m_data, m_par}) begin
                errors++;
                $display("FAIL basic_stream[%0d]: got %b %h %h want 1 %h %h",
                         i, out_vld, data_out, parity_out, m_data, m_par);
            end
        end
        cycle(0, '0, 1);
        checks++;
        if (out_vld !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got out_vld=%b want 0", out_vld);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w[4];
        for (int i = 0; i < 4; i++) w[i] = rand_word();
        sent.delete();
        got.delete();
        cycle(1, w[0], 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, w[1], 0);
            checks++;
            if ({in_rdy, out_vld, data_out, parity_out} !== {1'b0, 1'b1, w[0], ref_parity(w[0])}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got rdy=%b vld=%b data=%h par=%h want 0 1 %h %h",
                         i, in_rdy, out_vld, data_out, parity_out, w[0], ref_parity(w[0]));
            end
        end
        for (int i = 1; i < 4; i++) cycle(1, w[i], 1);
        cycle(0, '0, 1);
        checks++;
        if (got.size() != 4 || got[0] !== w[0] || got[1] !== w[1] || got[2] !== w[2]
            || got[3] !== w[3]) begin
            errors++;
            $display("FAIL stall_order: got %0d words want 4 in order", got.size());
        end
    endtask

    task automatic test_bypass();
        bypass = 1; en = 1;
        cycle(1, 61'h1FFF_FFFF_FFFF_FFFF, 1);
        checks++;
        if ({data_out, parity_out, ecc_fault} !== {61'h1FFF_FFFF_FFFF_FFFF, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL bypass: got data=%h par=%h flt=%b want 1fffffffffffffff 00 0",
                     data_out, parity_out, ecc_fault);
        end
        bypass = 0;
        cycle(0, '0, 1);
    endtask

    task automatic test_fault();
`ifdef ECC_ENC_FAULT_INJ_EN
        fault_clr = 1;
        cycle(0, '0, 1);
        fault_clr = 0;
        en = 1; inj_en = 1; inj_mask = 8'h10;
        cycle(1, 61'h1, 1);
        checks++;
        if ({parity_out, ecc_fault, fault_sticky, fault_cnt} !== {8'h80, 1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL inject: got par=%h flt=%b stk=%b cnt=%0d want 80 1 1 1",
                     parity_out, ecc_fault, fault_sticky, fault_cnt);
        end
        en = 0;
        cycle(1, 61'h1, 1);
        checks++;
        if ({parity_out, ecc_fault, fault_cnt} !== {8'h83, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL inject_disabled: got par=%h flt=%b cnt=%0d want 83 0 1",
                     parity_out, ecc_fault, fault_cnt);
        end
        en = 1;
        for (int i = 0; i < 300; i++) cycle(1, rand_word(), 1);
        checks++;
        if (fault_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturate: got cnt=%0d want 255", fault_cnt);
        end
        fault_clr = 1;
        cycle(1, rand_word(), 1);
        checks++;
        if ({fault_sticky, fault_cnt} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL clr_vs_set: got stk=%b cnt=%0d want 1 1", fault_sticky, fault_cnt);
        end
        cycle(0, '0, 1);
        fault_clr = 0;
        checks++;
        if ({fault_sticky, fault_cnt} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL clr: got stk=%b cnt=%0d want 0 0", fault_sticky, fault_cnt);
        end
        // Held word must ignore later changes to en/bypass
        cycle(1, 61'h1, 0);
        en = 0; bypass = 1;
        cycle(0, '0, 0);
        checks++;
        if ({out_vld, parity_out, ecc_fault} !== {1'b1, 8'h80, 1'b1}) begin
            errors++;
            $display("FAIL held_word: got vld=%b par=%h flt=%b want 1 80 1",
                     out_vld, parity_out, ecc_fault);
        end
        en = 1; bypass = 0; inj_en = 0;
        cycle(0, '0, 1);
`else
        en = 1;
        for (int i = 0; i < 20; i++) cycle(1, rand_word(), 1);
        checks++;
        if ({ecc_fault, fault_sticky, fault_cnt} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL no_fault: got flt=%b stk=%b cnt=%0d want 0 0 0",
                     ecc_fault, fault_sticky, fault_cnt);
        end
        cycle(0, '0, 1);
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            bypass    = ($urandom_range(0, 7) == 0);
            fault_clr = ($urandom_range(0, 15) == 0);
`ifdef ECC_ENC_FAULT_INJ_EN
            inj_en    = $urandom_range(0, 1);
            inj_mask  = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom());
`endif
            cycle($urandom_range(0, 1), rand_word(), ($urandom_range(0, 3) != 0));
            checks++;
            if ({in_rdy, out_vld, data_out, parity_out, ecc_fault, fault_sticky, fault_cnt}
                !== {(!m_vld || out_rdy), m_vld, m_data, m_par, m_fault, m_sticky, m_cnt}) begin
                errors++;
                $display("FAIL random[%0d]: got rdy=%b vld=%b d=%h p=%h f=%b s=%b c=%0d want vld=%b d=%h p=%h f=%b s=%b c=%0d",
                         i, in_rdy, out_vld, data_out, parity_out, ecc_fault, fault_sticky,
                         fault_cnt, m_vld, m_data, m_par, m_fault, m_sticky, m_cnt);
            end
        end
        en = 1; bypass = 0; fault_clr = 0; inj_en = 0;
    endtask

    task automatic test_reset_midhold();
        cycle(1, 61'h1, 0);
        cycle(1, rand_word(), 0);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({out_vld, data_out, parity_out, ecc_fault, fault_sticky, fault_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: got vld=%b data=%h par=%h want all 0",
                     out_vld, data_out, parity_out);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        in_vld = 0;
        #1;
        checks++;
        if ({in_rdy, out_vld} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b vld=%b want 1 0", in_rdy, out_vld);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_bypass();
        test_fault();
        test_random();
        test_reset_midhold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
